// File: rtl/beacon_burst_tx.sv
// beacon_burst_tx: keyed-carrier burst beacon.
// Enabled, it emits bursts of a square-wave carrier ON_TU time units long,
// one burst every PERIOD_TU time units. Time is counted in tu_en strobes.
// Optional build macro BURST_JITTER_EN adds 0..JITTER_TU time units of
// pseudo-random extra off-time per burst, drawn from a 16-bit LFSR.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | quiet, waiting for en_i
// S_ON   | carrier keyed, counting ON_TU time units
// S_OFF  | carrier off, counting off-time; then next burst or IDLE
module beacon_burst_tx #(
  parameter int CARRIER_DIV = 4,
  parameter int ON_TU       = 70,
  parameter int PERIOD_TU   = 1000,
  parameter int JITTER_TU   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        tu_en,
  output logic        carrier_o,
  output logic        keying_o,
  output logic        burst_start_o,
  output logic [15:0] burst_cnt_o
);

  localparam int TW = $clog2(PERIOD_TU + JITTER_TU + 1);
  localparam int DW = $clog2(CARRIER_DIV + 1);

  localparam logic [TW-1:0] ON_TGT   = TW'(ON_TU);
  localparam logic [TW-1:0] OFF_BASE = TW'(PERIOD_TU - ON_TU);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CARRIER_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [TW-1:0] r_tu_cnt;
  logic [TW-1:0] w_tu_nxt;
  logic [TW-1:0] w_tu_inc;
  logic [TW-1:0] w_off_tgt;
  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;
  logic          r_carrier;
  logic          w_carrier_nxt;
  logic          r_keying;
  logic          w_keying_nxt;
  logic          r_start;
  logic          w_start_nxt;
  logic [15:0]   r_cnt;
  logic [15:0]   w_cnt_nxt;
  logic          w_tu_hit_on;
  logic          w_tu_hit_off;
  logic          w_enter_on;

  assign w_tu_inc = r_tu_cnt + TW'(1);

  // The strobe landing in the first ON cycle is ignored, so the burst
  // always counts ON_TU whole strobes after its start.
  assign w_tu_hit_on  = tu_en && !r_start && (w_tu_inc == ON_TGT);
  assign w_tu_hit_off = tu_en && (w_tu_inc == w_off_tgt);

`ifdef BURST_JITTER_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_step;
  logic [15:0] w_lfsr_nxt;

  // Fibonacci taps 16,14,13,11 (bit n-1 for tap n), shifting toward the MSB.
  assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_lfsr_nxt  = w_enter_on ? w_lfsr_step : r_lfsr;

  // The LFSR only moves on ON entry, so the target is stable through OFF.
  assign w_off_tgt = OFF_BASE + TW'(32'(r_lfsr) % (JITTER_TU + 1));

  // LFSR advances once per burst start; reseeded by reset and clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else if (clr_i) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= w_lfsr_nxt;
    end
  end
`else
  assign w_off_tgt = OFF_BASE;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; clear overrides every other input
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (en_i) w_state_nxt = S_ON;
      S_ON:    if (w_tu_hit_on) w_state_nxt = S_OFF;
      S_OFF:   if (w_tu_hit_off) w_state_nxt = en_i ? S_ON : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (clr_i) w_state_nxt = S_IDLE;
  end

  assign w_enter_on = (w_state_nxt == S_ON) && (r_state != S_ON);

  // Next values of counters and outputs; carrier/keying fall together on
  // leaving ON since both come from the same registered decision
  always_comb begin
    w_tu_nxt      = r_tu_cnt;
    w_div_nxt     = r_div;
    w_carrier_nxt = 1'b0;
    w_keying_nxt  = 1'b0;
    w_start_nxt   = 1'b0;
    w_cnt_nxt     = r_cnt;
    if (w_enter_on) begin
      w_tu_nxt     = '0;
      w_div_nxt    = DIV_LOAD;
      w_keying_nxt = 1'b1;
      w_start_nxt  = 1'b1;
      if (r_cnt != 16'hFFFF) w_cnt_nxt = r_cnt + 16'd1;
    end else if (w_state_nxt != r_state) begin
      w_tu_nxt  = '0;
      w_div_nxt = '0;
    end else if (r_state == S_ON) begin
      w_keying_nxt = 1'b1;
      if (tu_en && !r_start) w_tu_nxt = w_tu_inc;
      if (r_div == '0) begin
        w_div_nxt     = DIV_LOAD;
        w_carrier_nxt = ~r_carrier;
      end else begin
        w_div_nxt     = r_div - DW'(1);
        w_carrier_nxt = r_carrier;
      end
    end else if (r_state == S_OFF) begin
      if (tu_en) w_tu_nxt = w_tu_inc;
    end
  end

  // Datapath and output registers; reset drops the carrier asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tu_cnt  <= '0;
      r_div     <= '0;
      r_carrier <= 1'b0;
      r_keying  <= 1'b0;
      r_start   <= 1'b0;
      r_cnt     <= '0;
    end else if (clr_i) begin
      r_tu_cnt  <= '0;
      r_div     <= '0;
      r_carrier <= 1'b0;
      r_keying  <= 1'b0;
      r_start   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_tu_cnt  <= w_tu_nxt;
      r_div     <= w_div_nxt;
      r_carrier <= w_carrier_nxt;
      r_keying  <= w_keying_nxt;
      r_start   <= w_start_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign carrier_o     = r_carrier;
  assign keying_o      = r_keying;
  assign burst_start_o = r_start;
  assign burst_cnt_o   = r_cnt;

endmodule

// File: tb/tb_beacon_burst_tx.sv
// Bench for beacon_burst_tx: directed reset/clear checks, then randomized
// segments scored against a burst-level reference model.
module tb_beacon_burst_tx;

  localparam int CD     = 4;
  localparam int ON_TU  = 3;
  localparam int PER_TU = 10;
  localparam int JIT_TU = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_i = 1'b0;
  logic        en_i = 1'b0;
  logic        tu_en = 1'b0;
  logic        carrier_o;
  logic        keying_o;
  logic        burst_start_o;
  logic [15:0] burst_cnt_o;

  beacon_burst_tx #(
    .CARRIER_DIV(CD),
    .ON_TU(ON_TU),
    .PERIOD_TU(PER_TU),
    .JITTER_TU(JIT_TU)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr_i(clr_i),
    .en_i(en_i),
    .tu_en(tu_en),
    .carrier_o(carrier_o),
    .keying_o(keying_o),
    .burst_start_o(burst_start_o),
    .burst_cnt_o(burst_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected burst: absolute start cycle, count shown then, keyed length.
  typedef struct {
    int start;
    int cnt;
    int on_len;
  } exp_t;

  exp_t exp_q[$];
  bit   s_en[$];
  bit   s_tu[$];
  int   seg_base;

  // Index of the n-th strobe at or after 'from', or -1.
  function automatic int nth_tu(input int from, input int n);
    int seen = 0;
    for (int k = from; k < s_tu.size(); k++) begin
      if (s_tu[k]) begin
        seen++;
        if (seen == n) return k;
      end
    end
    return -1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Walks the stimulus arrays burst by burst: a burst starts the cycle after
  // en_i is seen in idle, is keyed until its ON_TU-th strobe (start cycle's
  // strobe excluded), then waits off_len strobes and chains or goes idle.
  task automatic build_expect();
    int L = s_en.size();
    int i = 0;
    int start;
    int on_end;
    int off_end;
    int off_len;
    int cnt = 0;
    bit done = 0;
    bit idle;
`ifdef BURST_JITTER_EN
    logic [15:0] lf = 16'hACE1;
`endif
    while (!done) begin
      while (i < L && !s_en[i]) i++;
      if (i >= L - 1) break;
      start = i + 1;
      idle  = 0;
      while (!idle && !done) begin
        cnt = (cnt < 65535) ? cnt + 1 : cnt;
`ifdef BURST_JITTER_EN
        lf      = lfsr_step(lf);
        off_len = PER_TU - ON_TU + (int'(lf) % (JIT_TU + 1));
`else
        off_len = PER_TU - ON_TU;
`endif
        on_end = nth_tu(start + 1, ON_TU);
        if (on_end < 0) begin
          done = 1;
        end else begin
          exp_q.push_back('{seg_base + start, cnt, on_end - start + 1});
          off_end = nth_tu(on_end + 1, off_len);
          if (off_end < 0) done = 1;
          else if (s_en[off_end]) start = off_end + 1;
          else begin
            i    = off_end + 1;
            idle = 1;
          end
        end
      end
    end
  endtask

  // Monitor: pops an expectation on every burst_start_o and checks the
  // keyed window and carrier shape against it.
  bit   mon_en = 0;
  bit   mon_active = 0;
  bit   mon_ok = 0;
  int   mon_j = 0;
  int   mon_len = 0;
  int   mon_bad = -1;
  exp_t mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!keying_o) chk("carrier_low_when_unkeyed", int'(carrier_o), 0);
      if (burst_start_o) begin
        if (mon_active) chk("burst_len_at_restart", mon_j, mon_len);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_burst: burst_start_o=1 at cycle %0d, expected none", cyc);
          mon_active = 0;
        end else begin
          mon_e = exp_q.pop_front();
          chk("burst_start_cycle", cyc, mon_e.start);
          chk("burst_cnt", int'(burst_cnt_o), mon_e.cnt);
          mon_len    = mon_e.on_len;
          mon_j      = 0;
          mon_ok     = 1;
          mon_bad    = -1;
          mon_active = 1;
        end
      end
      if (mon_active) begin
        if (mon_j < mon_len) begin
          if (keying_o != 1'b1 || int'(carrier_o) != ((mon_j / CD) % 2)) begin
            if (mon_ok) mon_bad = mon_j;
            mon_ok = 0;
          end
          mon_j++;
        end else begin
          chk("keying_low_after_burst", int'(keying_o), 0);
          chk("burst_shape_first_bad_cycle", mon_bad, -1);
          mon_active = 0;
        end
      end
    end
  end

  // One randomized segment, opened by a clear (optionally with a strobe).
  // en_mode: 0 held high, 1 dropped 5 clk into first burst, 2 random toggles.
  // tu_mode: 0 every 8 clk, 1 random density. The tail keeps en_i low with
  // regular strobes so the DUT is idle at the end of every segment.
  task automatic run_seg(input int act_len, input int tail_len, input int en_mode,
                         input int tu_mode, input bit tu_on_clr);
    int p = $urandom_range(1, 12);
    bit cur_en = 1'b1;
    s_en.delete();
    s_tu.delete();
    for (int k = 0; k < act_len; k++) begin
      if (en_mode == 1) cur_en = (k < 6);
      else if (en_mode == 2 && $urandom_range(0, 29) == 0) cur_en = ~cur_en;
      s_en.push_back(cur_en);
      if (tu_mode == 0) s_tu.push_back(k % 8 == 0);
      else s_tu.push_back($urandom_range(0, p - 1) == 0);
    end
    for (int k = 0; k < tail_len; k++) begin
      s_en.push_back(1'b0);
      s_tu.push_back(k % 4 == 0);
    end
    @(negedge clk);
    clr_i = 1'b1;
    tu_en = tu_on_clr;
    en_i  = 1'($urandom_range(0, 1));
    @(negedge clk);
    clr_i = 1'b0;
    chk("clr_burst_cnt", int'(burst_cnt_o), 0);
    chk("clr_keying", int'(keying_o), 0);
    seg_base = cyc;
    build_expect();
    mon_en = 1;
    for (int k = 0; k < s_en.size(); k++) begin
      en_i  = s_en[k];
      tu_en = s_tu[k];
      @(negedge clk);
    end
    en_i  = 1'b0;
    tu_en = 1'b0;
    chk("seg_bursts_left_unseen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int highs;
    int dk;
    bit got;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_carrier", int'(carrier_o), 0);
    chk("rst_keying", int'(keying_o), 0);
    chk("rst_burst_start", int'(burst_start_o), 0);
    chk("rst_burst_cnt", int'(burst_cnt_o), 0);
    rst = 1'b0;

    // No burst without en_i
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      tu_en = (k % 8 == 0);
      @(negedge clk);
      if (keying_o || burst_start_o) highs++;
    end
    chk("no_burst_without_en", highs, 0);

    // Reset mid-burst drops keying without a clock edge
    dk  = 0;
    got = 0;
    en_i = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      tu_en = (dk % 8 == 0);
      dk++;
      @(negedge clk);
      if (burst_start_o) got = 1;
    end
    chk("first_burst_started", int'(got), 1);
    for (int k = 0; k < 10; k++) begin
      tu_en = (dk % 8 == 0);
      dk++;
      @(negedge clk);
    end
    chk("keyed_before_rst", int'(keying_o), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_keying", int'(keying_o), 0);
    chk("async_rst_carrier", int'(carrier_o), 0);
    chk("async_rst_burst_cnt", int'(burst_cnt_o), 0);
    @(negedge clk);
    rst  = 1'b0;
    en_i = 1'b0;
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      tu_en = (k % 8 == 0);
      @(negedge clk);
      if (keying_o || burst_start_o) highs++;
    end
    chk("no_restart_after_rst_without_en", highs, 0);
    en_i = 1'b1;
    dk   = 0;
    got  = 0;
    for (int k = 0; k < 4 && !got; k++) begin
      tu_en = (dk % 8 == 0);
      dk++;
      @(negedge clk);
      if (burst_start_o) got = 1;
    end
    chk("restart_with_en", int'(got), 1);
    chk("restart_burst_cnt", int'(burst_cnt_o), 1);

    // Run into OFF, then the first segment clears with a strobe in OFF
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      tu_en = (dk % 8 == 0);
      dk++;
      @(negedge clk);
      if (!keying_o) got = 1;
    end
    chk("reached_off", int'(got), 1);
    for (int k = 0; k < 3; k++) begin
      tu_en = (dk % 8 == 0);
      dk++;
      @(negedge clk);
    end
    tu_en = 1'b0;
    run_seg(1800, 300, 0, 0, 1'b1);
    run_seg(300, 300, 1, 0, 1'b0);
    for (int r = 0; r < 18; r++) begin
      run_seg(300, 300, (r % 3 == 0) ? 0 : 2, 1, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("monitor_idle_at_end", int'(mon_active), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/beacon_burst_tx.md
BEACON_BURST_TX -- requirements
Module: beacon_burst_tx

Interface
REQ-001 SHALL have parameter CARRIER_DIV, default 4: clk cycles per carrier half-period (>=1).
REQ-002 SHALL have parameter ON_TU, default 70: burst on-time in time units (>=1).
REQ-003 SHALL have parameter PERIOD_TU, default 1000: burst period in time units (>ON_TU).
REQ-004 SHALL have parameter JITTER_TU, default 15: maximum extra off-time in time units, used only under REQ-030.
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port clr_i  input  1  synchronous clear, same effect as reset.
REQ-008 SHALL have port en_i  input  1  transmit enable (level).
REQ-009 SHALL have port tu_en  input  1  one-cycle time-unit strobe.
REQ-010 SHALL have port carrier_o  output  1  keyed square-wave carrier.
REQ-011 SHALL have port keying_o  output  1  high while in ON.
REQ-012 SHALL have port burst_start_o  output  1  one-cycle pulse on the first ON cycle of each burst.
REQ-013 SHALL have port burst_cnt_o  output  16  bursts started since reset/clear, saturating at 16'hFFFF.

Function
REQ-014 SHALL implement FSM states IDLE, ON, OFF, all outputs registered.
REQ-015 IDLE: en_i high on a cycle -> ON on the next cycle; otherwise stay IDLE.
REQ-016 ON entry SHALL assert burst_start_o for exactly one cycle, increment burst_cnt_o (saturating) and clear the TU counter and carrier phase.
REQ-017 ON: carrier_o SHALL start low and toggle every CARRIER_DIV clk cycles (period 2*CARRIER_DIV), independent of tu_en.
REQ-018 ON: TU counter SHALL increment on each tu_en; the tu_en that makes the count equal ON_TU -> OFF next cycle, counter cleared.
REQ-019 OFF: carrier_o and keying_o SHALL be low; TU counter increments on tu_en; on reaching PERIOD_TU-ON_TU (+ jitter under REQ-030) -> ON if en_i high that cycle, else IDLE.
REQ-020 en_i deassertion during ON SHALL NOT truncate the burst; the burst completes, then the FSM goes to IDLE at the end of OFF.
REQ-021 carrier_o SHALL be low whenever keying_o is low, with no glitch on the ON->OFF transition.
REQ-022 TU counter width SHALL be $clog2(PERIOD_TU+JITTER_TU+1); the carrier divider width SHALL be $clog2(CARRIER_DIV+1).
REQ-023 clr_i SHALL take priority over en_i and tu_en in the same cycle.
REQ-024 tu_en in the cycle of ON entry SHALL be ignored (the counter starts at 0 in the following cycle).

Reset
REQ-025 On rst: state=IDLE, carrier_o=0, keying_o=0, burst_start_o=0, burst_cnt_o=0, all counters 0.
REQ-026 Reset asserted mid-burst SHALL force carrier_o/keying_o low immediately (asynchronously).
REQ-027 clr_i SHALL produce the REQ-025 state on the next clk edge.
REQ-028 First burst after reset release SHALL require en_i high in IDLE.

Configuration
REQ-029 Macro BURST_JITTER_EN SHALL select off-time jitter.
REQ-030 With BURST_JITTER_EN: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset/clear) SHALL step once per burst start; off-time = PERIOD_TU-ON_TU + (LFSR mod (JITTER_TU+1)).
REQ-031 Without BURST_JITTER_EN: no LFSR SHALL be implemented; off-time is exactly PERIOD_TU-ON_TU and JITTER_TU is ignored.

Verification (CARRIER_DIV=4, ON_TU=3, PERIOD_TU=10, tu_en every 8 clk, macro off unless stated)
REQ-032 en_i held high -> burst_start_o pulses every 80 clk (+/-1); keying_o high for 24 clk; burst_cnt_o=3 after 3 bursts.
REQ-033 During ON -> carrier_o toggles every 4 clk starting low; carrier_o=0 throughout OFF and IDLE.
REQ-034 en_i dropped 5 clk into a burst -> full 24-clk burst completes, OFF completes, then IDLE; no further burst_start_o.
REQ-035 rst asserted 10 clk into ON -> carrier_o/keying_o low without waiting for clk; burst_cnt_o=0; restart needs en_i.
REQ-036 clr_i and tu_en in the same cycle during OFF -> IDLE and counters 0 next cycle.
REQ-037 BURST_JITTER_EN defined, JITTER_TU=3 -> off-times of 7..10 TU observed over 20 bursts, each matching the LFSR reference model.
